keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per scan tick (1 ms at 50 MHz); minimum 2.
REQ-002 Parameter DEBOUNCE_TICKS, default 20, consecutive stable scan ticks required for press and for release; minimum 1.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port col_in  input  4  keypad columns, active-low, externally pulled up, asynchronous to clk.
REQ-006 Port row_out  output  4  keypad row drive, active-low, at most one bit low during scanning.
REQ-007 Port Value_en  output  1  one-cycle strobe, high when a debounced new key press is reported.
REQ-008 Port KEY_Value  output  4  code of last reported key; valid when Value_en high, held until next report.
REQ-009 Port key_held  output  1  high from report until debounced release completes.

Function
REQ-010 col_in SHALL pass through a 2-flop synchronizer; all decisions use synchronized columns only.
REQ-011 Tick counter SHALL count 0..SCAN_DIV-1 and wrap; scan_tick true on the cycle count equals SCAN_DIV-1.
REQ-012 States: IDLE, SCAN, DEBOUNCE, REPORT, HOLD, RELEASE; state changes occur only on scan_tick, except REPORT->HOLD.
REQ-013 IDLE: row_out=4'b0000; on scan_tick with any synchronized column low -> SCAN with row index 0.
REQ-014 SCAN: row_out drives only row[idx] low; on scan_tick sample columns for that row (one full tick settle).
REQ-015 SCAN sample with exactly one column low -> latch row/col, clear debounce counter, -> DEBOUNCE.
REQ-016 SCAN sample with no column low -> idx+1; after idx 3 with nothing found -> IDLE.
REQ-017 SCAN sample with two or more columns low (ghost/multi-key) -> HOLD without report.
REQ-018 DEBOUNCE: on each scan_tick, same single column low -> counter+1; else -> IDLE, no report.
REQ-019 When counter reaches DEBOUNCE_TICKS -> REPORT; REPORT lasts exactly one clk cycle.
REQ-020 In REPORT: Value_en=1, KEY_Value=KEYMAP[row*4+col], key_held set; -> HOLD next cycle.
REQ-021 HOLD: row_out keeps latched row low; on scan_tick with latched column high -> RELEASE, counter cleared.
REQ-022 RELEASE: on scan_tick, column still high -> counter+1; column low again -> HOLD; counter==DEBOUNCE_TICKS -> IDLE, key_held cleared.
REQ-023 Exactly one Value_en pulse per physical press; auto-repeat is not provided.
REQ-024 Keys pressed while in HOLD/RELEASE SHALL be ignored until IDLE is reached.
REQ-025 KEYMAP (row: cols 0..3): r0 1,2,3,11; r1 4,5,6,12; r2 7,8,9,13; r3 15,0,10,14 (A=11,B=12,C=13,D=14,E=15).
REQ-026 Debounce counter width SHALL be clog2(DEBOUNCE_TICKS+1); saturates, never wraps.

Reset
REQ-027 On rst high at a clk edge: state=IDLE, row_out=4'b0000, Value_en=0, KEY_Value=4'd0, key_held=0, tick and debounce counters=0, synchronizer flops=4'b1111.
REQ-028 rst asserted mid-press SHALL abort without a Value_en pulse; a key still held after rst deassertion is re-debounced and reported once.

Structure
REQ-029 Shared package holds state enumeration, KEYMAP table, key-code constants (KEY_A..KEY_E) shared with the clock-status consumer.
REQ-030 One sub-module, sync_2ff (parameterized width), implements REQ-010; the rest is a single FSM block.

Verification (SCAN_DIV=4, DEBOUNCE_TICKS=3, keypad model resolves row_out x pressed key)
REQ-031 Press r1c2, hold 40 ticks -> exactly one Value_en, KEY_Value=6, key_held=1; release -> key_held=0 after 3 stable ticks.
REQ-032 Press r0c3 for 2 ticks then release -> no Value_en; state back to IDLE.
REQ-033 Press r3c1 with release bounce (high 1 tick, low 1 tick, then high) -> single report KEY_Value=0, no second pulse.
REQ-034 Press r2c0 and r2c2 together -> no Value_en; after both released, press r2c1 -> KEY_Value=8.
REQ-035 Assert rst for 1 cycle during DEBOUNCE of r0c0 -> outputs at reset values, then one report KEY_Value=1 if still held.
REQ-036 Sequence A,1,2 -> three pulses with KEY_Value 11,1,2, each Value_en exactly 1 clk wide.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, key-code constants
// and the row/column-to-code map, also used by consumers of KEY_Value.
package keypad_scan_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_REPORT   = 3'd3,
    ST_HOLD     = 3'd4,
    ST_RELEASE  = 3'd5
  } state_e;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_A = 4'd11;
  localparam key_code_t KEY_B = 4'd12;
  localparam key_code_t KEY_C = 4'd13;
  localparam key_code_t KEY_D = 4'd14;
  localparam key_code_t KEY_E = 4'd15;

  // Indexed by {row, col}; element [15] is leftmost in the concatenation.
  localparam logic [15:0][3:0] KEYMAP = {
    KEY_D, 4'd10, 4'd0, KEY_E,   // row 3, cols 3..0
    KEY_C, 4'd9,  4'd8, 4'd7,    // row 2
    KEY_B, 4'd6,  4'd5, 4'd4,    // row 1
    KEY_A, 4'd3,  4'd2, 4'd1     // row 0
  };

  // Number of active-low (pressed) lines in a column vector.
  function automatic logic [2:0] count_low(input logic [NUM_COLS-1:0] cols);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      n = n + {2'b00, ~cols[i]};
    end
    return n;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_COLS-1:0] onehot);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (onehot[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic key_code_t key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEYMAP[{row, col}];
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix lines plus the key-report outputs of the scanner.
interface keypad_scan_if;

  logic [keypad_scan_pkg::NUM_COLS-1:0] col_in;
  logic [keypad_scan_pkg::NUM_ROWS-1:0] row_out;
  logic                                 Value_en;
  logic [3:0]                           KEY_Value;
  logic                                 key_held;

  // Scanner side.
  modport master (
    input  col_in,
    output row_out,
    output Value_en,
    output KEY_Value,
    output key_held
  );

  // Keypad / consumer side.
  modport slave (
    output col_in,
    input  row_out,
    input  Value_en,
    input  KEY_Value,
    input  key_held
  );

endinterface

// File: rtl/keypad_scan_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, with a configurable
// reset value so idle-high lines do not look active after reset.
module sync_2ff #(
  parameter int unsigned           WIDTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments make both stages sample on the same edge,
  // which is what keeps this a two-stage shift instead of a single wire.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: tick-paced row scan, press/release debounce,
// one Value_en strobe per debounced press, ghost (multi-key) rejection.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master kp
);

  localparam int unsigned TICK_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_TICKS);

  logic [NUM_COLS-1:0] col_s;
  logic [NUM_COLS-1:0] col_low;
  logic [2:0]          n_low;

  logic [TICK_W-1:0]   tick_q;
  logic                scan_tick;

  state_e              state_q, state_d;
  logic [1:0]          row_idx_q, row_idx_d;
  logic [NUM_COLS-1:0] col_mask_q, col_mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  key_code_t           key_value_q, key_value_d;
  logic                key_held_q, key_held_d;

  logic [NUM_ROWS-1:0] row_sel;
  logic [NUM_ROWS-1:0] row_drive;
  logic                cols_released;
  logic                same_key;

  // NOTE: the synchronizer resets to all-ones (no key) so the FSM never sees
  // a phantom press in the cycles straight after reset.
  sync_2ff #(
    .WIDTH     (NUM_COLS),
    .RESET_VAL (4'b1111)
  ) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d_i (kp.col_in),
    .q_o (col_s)
  );

  assign col_low = ~col_s;
  assign n_low   = count_low(col_s);

  assign scan_tick = (tick_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
    end else if (scan_tick) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + TICK_W'(1);
    end
  end

  // Saturating so a long stable run can never wrap back to zero.
  assign cnt_inc       = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + CNT_W'(1);
  assign row_sel       = ~(4'b0001 << row_idx_q);
  assign cols_released = ((col_s & col_mask_q) == col_mask_q);
  assign same_key      = (col_low == col_mask_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      row_idx_q   <= '0;
      col_mask_q  <= '0;
      cnt_q       <= '0;
      key_value_q <= '0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      col_mask_q  <= col_mask_d;
      cnt_q       <= cnt_d;
      key_value_q <= key_value_d;
      key_held_q  <= key_held_d;
    end
  end

  // NOTE: every output of this block is given a default before the case so
  // no path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    col_mask_d  = col_mask_q;
    cnt_d       = cnt_q;
    key_value_d = key_value_q;
    key_held_d  = key_held_q;
    row_drive   = row_sel;

    unique case (state_q)
      ST_IDLE: begin
        row_drive = 4'b0000;
        if (scan_tick && (col_low != '0)) begin
          state_d   = ST_SCAN;
          row_idx_d = 2'd0;
        end
      end

      ST_SCAN: begin
        if (scan_tick) begin
          if (n_low == 3'd0) begin
            if (row_idx_q == 2'd3) begin
              state_d = ST_IDLE;
            end else begin
              row_idx_d = row_idx_q + 2'd1;
            end
          end else if (n_low == 3'd1) begin
            col_mask_d = col_low;
            cnt_d      = '0;
            state_d    = ST_DEBOUNCE;
          end else begin
            // Ghost / multi-key: wait out the release without reporting.
            col_mask_d = col_low;
            state_d    = ST_HOLD;
          end
        end
      end

      ST_DEBOUNCE: begin
        if (scan_tick) begin
          if (same_key) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d     = ST_REPORT;
              key_value_d = key_lookup(row_idx_q, onehot_to_idx(col_mask_q));
              key_held_d  = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_REPORT: begin
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        if (scan_tick && cols_released) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (scan_tick) begin
          if (cols_released) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d    = ST_IDLE;
              key_held_d = 1'b0;
            end
          end else begin
            state_d = ST_HOLD;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign kp.row_out   = row_drive;
  assign kp.Value_en  = (state_q == ST_REPORT);
  assign kp.KEY_Value = key_value_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a keypad matrix model, a tick-level
// behavioural reference checked every cycle, directed scenarios and random presses.
module tb_keypad_scan;

  localparam int DIV = 4;
  localparam int DT  = 3;

  localparam int MD_IDLE      = 0;
  localparam int MD_SCAN      = 1;
  localparam int MD_CONFIRM   = 2;
  localparam int MD_REPORT    = 3;
  localparam int MD_HELD      = 4;
  localparam int MD_RELEASING = 5;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic [15:0] pressed = '0;
  logic [3:0]  col_drv;

  keypad_scan_if kp ();

  keypad_scan #(
    .SCAN_DIV       (DIV),
    .DEBOUNCE_TICKS (DT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp.master)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_drv = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && (kp.row_out[r] == 1'b0)) col_drv[c] = 1'b0;
      end
    end
  end
  assign kp.col_in = col_drv;

  int keytab [16] = '{1, 2, 3, 11, 4, 5, 6, 12, 7, 8, 9, 13, 15, 0, 10, 14};

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int         m_mode   = MD_IDLE;
  int         m_tcnt   = 0;
  int         m_row    = 0;
  int         m_streak = 0;
  logic [3:0] m_s1     = 4'hF;
  logic [3:0] m_s2     = 4'hF;
  logic [3:0] m_mask   = 4'h0;
  logic [3:0] m_key    = 4'h0;
  bit         m_held   = 1'b0;

  logic [3:0] col_at_edge;
  logic       rst_at_edge;
  bit         edge_seen = 1'b0;

  int got_keys [$];
  int run_len = 0;
  int max_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int col_of(input logic [3:0] mask);
    int col;
    col = 0;
    for (int i = 0; i < 4; i++) if (mask[i]) col = i;
    return col;
  endfunction

  function automatic logic [3:0] model_rows();
    if (m_mode == MD_IDLE) return 4'b0000;
    return ~(4'b0001 << m_row);
  endfunction

  // One scan tick of the keypad rules, applied to the columns the scanner sees.
  task automatic model_tick(input logic [3:0] seen);
    logic [3:0] low;
    int         n;
    bit         up;
    low = ~seen;
    n   = $countones(low);
    up  = ((seen & m_mask) == m_mask);
    case (m_mode)
      MD_IDLE: if (n != 0) begin
        m_mode = MD_SCAN;
        m_row  = 0;
      end
      MD_SCAN: begin
        if (n == 0) begin
          if (m_row == 3) m_mode = MD_IDLE;
          else m_row = m_row + 1;
        end else begin
          m_mask   = low;
          m_streak = 0;
          m_mode   = (n == 1) ? MD_CONFIRM : MD_HELD;
        end
      end
      MD_CONFIRM: begin
        if (low == m_mask) begin
          m_streak = m_streak + 1;
          if (m_streak >= DT) begin
            m_mode = MD_REPORT;
            m_key  = 4'(keytab[m_row*4 + col_of(m_mask)]);
            m_held = 1'b1;
          end
        end else begin
          m_mode = MD_IDLE;
        end
      end
      MD_HELD: if (up) begin
        m_streak = 0;
        m_mode   = MD_RELEASING;
      end
      MD_RELEASING: begin
        if (up) begin
          m_streak = m_streak + 1;
          if (m_streak >= DT) begin
            m_mode = MD_IDLE;
            m_held = 1'b0;
          end
        end else begin
          m_mode = MD_HELD;
        end
      end
      default: m_mode = MD_IDLE;
    endcase
  endtask

  task automatic model_step(input logic r, input logic [3:0] cin);
    logic [3:0] seen;
    bit         tick;
    if (r) begin
      m_mode = MD_IDLE; m_tcnt = 0; m_row = 0; m_streak = 0;
      m_s1 = 4'hF; m_s2 = 4'hF; m_mask = 4'h0; m_key = 4'h0; m_held = 1'b0;
    end else begin
      seen   = m_s2;
      m_s2   = m_s1;
      m_s1   = cin;
      tick   = (m_tcnt == DIV - 1);
      m_tcnt = tick ? 0 : m_tcnt + 1;
      if (m_mode == MD_REPORT) m_mode = MD_HELD;
      else if (tick) model_tick(seen);
    end
  endtask

  always @(posedge clk) begin
    col_at_edge <= kp.col_in;
    rst_at_edge <= rst;
    edge_seen   <= 1'b1;
  end

  // Advance the model for the edge just passed, compare, and log report pulses.
  always @(negedge clk) begin
    if (edge_seen) begin
      model_step(rst_at_edge, col_at_edge);
      check("row_out",   {28'd0, kp.row_out},   {28'd0, model_rows()});
      check("Value_en",  {31'd0, kp.Value_en},  {31'd0, (m_mode == MD_REPORT)});
      check("KEY_Value", {28'd0, kp.KEY_Value}, {28'd0, m_key});
      check("key_held",  {31'd0, kp.key_held},  {31'd0, m_held});
      if (kp.Value_en === 1'b1) begin
        got_keys.push_back(int'(kp.KEY_Value));
        run_len = run_len + 1;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    cycles(n * DIV);
  endtask

  task automatic key(input int r, input int c, input bit v);
    pressed[r*4+c] = v;
  endtask

  function automatic int key_at(input int i);
    if (i < got_keys.size()) return got_keys[i];
    return -1;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (((kp.row_out !== 4'b0000) || (kp.key_held !== 1'b0)) && (n < 400)) begin
      cycles(1);
      n++;
    end
    check(name, {27'd0, kp.key_held, kp.row_out}, 32'd0);
  endtask

  task automatic start_scenario(input string name);
    pressed = '0;
    wait_idle(name);
    got_keys.delete();
    max_run = 0;
  endtask

  int kind, r1, c1, r2, c2;

  initial begin
    rst = 1'b1;
    cycles(3);
    check("rst_row_out",   {28'd0, kp.row_out},   32'd0);
    check("rst_Value_en",  {31'd0, kp.Value_en},  32'd0);
    check("rst_KEY_Value", {28'd0, kp.KEY_Value}, 32'd0);
    check("rst_key_held",  {31'd0, kp.key_held},  32'd0);
    rst = 1'b0;
    ticks(2);

    // Press r1c2, hold, then release.
    start_scenario("s1_idle");
    key(1, 2, 1'b1);
    ticks(40);
    check("s1_pulses",   got_keys.size(), 32'd1);
    check("s1_key",      key_at(0), 32'd6);
    check("s1_held",     {31'd0, kp.key_held}, 32'd1);
    key(1, 2, 1'b0);
    ticks(1);
    check("s1_held_during_release", {31'd0, kp.key_held}, 32'd1);
    ticks(5);
    check("s1_released", {31'd0, kp.key_held}, 32'd0);
    check("s1_pulses_after", got_keys.size(), 32'd1);

    // Short press: no report.
    start_scenario("s2_idle");
    key(0, 3, 1'b1);
    ticks(2);
    key(0, 3, 1'b0);
    ticks(8);
    check("s2_pulses",  got_keys.size(), 32'd0);
    check("s2_row_out", {28'd0, kp.row_out}, 32'd0);
    check("s2_held",    {31'd0, kp.key_held}, 32'd0);

    // Release bounce.
    start_scenario("s3_idle");
    key(3, 1, 1'b1);
    ticks(20);
    key(3, 1, 1'b0);
    ticks(1);
    key(3, 1, 1'b1);
    ticks(1);
    key(3, 1, 1'b0);
    ticks(10);
    check("s3_pulses", got_keys.size(), 32'd1);
    check("s3_key",    key_at(0), 32'd0);
    check("s3_held",   {31'd0, kp.key_held}, 32'd0);

    // Ghost pair in row 2, then a clean r2c1.
    start_scenario("s4_idle");
    key(2, 0, 1'b1);
    key(2, 2, 1'b1);
    ticks(20);
    check("s4_ghost_pulses",  got_keys.size(), 32'd0);
    check("s4_ghost_held",    {31'd0, kp.key_held}, 32'd0);
    check("s4_ghost_row_out", {28'd0, kp.row_out}, 32'b1011);
    pressed = '0;
    ticks(10);
    check("s4_ghost_idle", {28'd0, kp.row_out}, 32'd0);
    key(2, 1, 1'b1);
    ticks(15);
    check("s4_pulses", got_keys.size(), 32'd1);
    check("s4_key",    key_at(0), 32'd8);

    // Reset during debounce of r0c0.
    start_scenario("s5_idle");
    key(0, 0, 1'b1);
    ticks(3);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("s5_rst_row_out",   {28'd0, kp.row_out},   32'd0);
    check("s5_rst_Value_en",  {31'd0, kp.Value_en},  32'd0);
    check("s5_rst_KEY_Value", {28'd0, kp.KEY_Value}, 32'd0);
    check("s5_rst_key_held",  {31'd0, kp.key_held},  32'd0);
    check("s5_rst_pulses",    got_keys.size(), 32'd0);
    ticks(15);
    check("s5_pulses", got_keys.size(), 32'd1);
    check("s5_key",    key_at(0), 32'd1);

    // Sequence A, 1, 2.
    start_scenario("s6_idle");
    key(0, 3, 1'b1); ticks(12); key(0, 3, 1'b0); ticks(8);
    key(0, 0, 1'b1); ticks(12); key(0, 0, 1'b0); ticks(8);
    key(0, 1, 1'b1); ticks(12); key(0, 1, 1'b0); ticks(8);
    check("s6_pulses", got_keys.size(), 32'd3);
    check("s6_key0",   key_at(0), 32'd11);
    check("s6_key1",   key_at(1), 32'd1);
    check("s6_key2",   key_at(2), 32'd2);
    check("s6_width",  max_run, 32'd1);

    // Random presses, multi-key, bounces and occasional reset.
    start_scenario("rnd_idle");
    for (int it = 0; it < 120; it++) begin
      kind = $urandom_range(0, 9);
      r1 = $urandom_range(0, 3); c1 = $urandom_range(0, 3);
      r2 = $urandom_range(0, 3); c2 = $urandom_range(0, 3);
      if (kind < 7) begin
        key(r1, c1, 1'b1);
      end else if (kind < 9) begin
        key(r1, c1, 1'b1);
        key(r2, c2, 1'b1);
      end
      cycles($urandom_range(2, 70));
      if ($urandom_range(0, 3) == 0) begin
        pressed = '0;
        cycles($urandom_range(1, 8));
        key(r1, c1, 1'b1);
        cycles($urandom_range(1, 30));
      end
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
      end
      pressed = '0;
      cycles($urandom_range(1, 60));
    end
    start_scenario("rnd_final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
